// File: rtl/aes_wb_sequencer.sv
// aes_wb_sequencer
//   Wishbone master that runs one AES-128 encryption on aes_top_wb per request:
//   writes 4 key words, 4 plaintext words and the start register, polls the
//   done bit, reads 4 ciphertext words and returns them on a response port.
//
//   Ports
//     wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//     req_valid_i/req_ready_o       request handshake, req_key_i/req_pt_i (word 0 = [127:96])
//     rsp_valid_o/rsp_ready_i       response handshake, rsp_ct_o, rsp_err_o
//     busy_o                        FSM not idle
//     wbm_*                         classic wishbone master, one beat at a time
//
//   Optional feature: define AES_SEQ_KEY_CACHE_EN to remember the last key that
//   completed without error and skip the key writes when it is requested again.
module aes_wb_sequencer #(
  parameter int            AW         = 30,
  parameter logic [AW-1:0] PT_BASE    = 'h00,
  parameter logic [AW-1:0] KEY_BASE   = 'h04,
  parameter logic [AW-1:0] START_ADDR = 'h08,
  parameter logic [AW-1:0] DONE_ADDR  = 'h09,
  parameter logic [AW-1:0] CT_BASE    = 'h0A,
  parameter int            POLL_LIMIT = 64
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [127:0]  req_key_i,
  input  logic [127:0]  req_pt_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [127:0]  rsp_ct_o,
  output logic          rsp_err_o,
  output logic          busy_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, WR_KEY, WR_PT, WR_START, POLL, RD_CT, RESP} state_t;

  state_t         state, state_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [PCW-1:0] poll_cnt;
  logic [127:0]   key_q, pt_q, ct_q;
  logic           cyc_q, we_q, err_q;
  logic [AW-1:0]  adr_q;
  logic [31:0]    dat_q;
  logic           handshake, issue, fail, key_hit, resp_ok;
  logic [AW-1:0]  beat_adr;
  logic           beat_we;
  logic [31:0]    beat_dat;

  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[127:96];
      2'd1:    return v[95:64];
      2'd2:    return v[63:32];
      default: return v[31:0];
    endcase
  endfunction

  assign handshake = req_valid_i && req_ready_o;

  // Address/data of the beat selected by the current state and word index.
  always_comb begin
    beat_adr = '0;
    beat_we  = 1'b0;
    beat_dat = '0;
    case (state)
      WR_KEY:   begin beat_adr = KEY_BASE + AW'(idx[1:0]); beat_we = 1'b1; beat_dat = word_sel(key_q, idx[1:0]); end
      WR_PT:    begin beat_adr = PT_BASE + AW'(idx[1:0]);  beat_we = 1'b1; beat_dat = word_sel(pt_q, idx[1:0]); end
      WR_START: begin beat_adr = START_ADDR; beat_we = 1'b1; beat_dat = 32'h1; end
      POLL:     beat_adr = DONE_ADDR;
      RD_CT:    beat_adr = CT_BASE + AW'(idx[1:0]);
      default:  ;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      poll_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state != POLL && state_nxt == POLL)
        poll_cnt <= '0;
      else if (state == POLL && cyc_q && wbm_ack_i && !wbm_err_i && poll_cnt != PCW'(POLL_LIMIT))
        poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Next-state logic. A bus state alternates between an idle slot (cyc low,
  // issue the next beat) and a beat in flight (wait for ack/err). The last
  // ciphertext ack parks idx at 4 so RESP is entered after the idle slot.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    issue     = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = key_hit ? WR_PT : WR_KEY;
          idx_nxt   = '0;
        end
      end
      WR_KEY, WR_PT, WR_START, POLL, RD_CT: begin
        if (!cyc_q) begin
          if (state == RD_CT && idx == 3'd4) state_nxt = RESP;
          else                               issue     = 1'b1;
        end else if (wbm_err_i) begin
          // err wins over a simultaneous ack
          state_nxt = RESP;
          fail      = 1'b1;
        end else if (wbm_ack_i) begin
          case (state)
            WR_KEY: begin
              if (idx == 3'd3) begin state_nxt = WR_PT; idx_nxt = '0; end
              else idx_nxt = idx + 3'd1;
            end
            WR_PT: begin
              if (idx == 3'd3) begin state_nxt = WR_START; idx_nxt = '0; end
              else idx_nxt = idx + 3'd1;
            end
            WR_START: state_nxt = POLL;
            POLL: begin
              if (wbm_dat_i[0]) begin
                state_nxt = RD_CT;
                idx_nxt   = '0;
              end else if (poll_cnt >= PCW'(POLL_LIMIT - 1)) begin
                state_nxt = RESP;
                fail      = 1'b1;
              end
            end
            default: idx_nxt = idx + 3'd1;
          endcase
        end
      end
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_ok = (state != RESP) && (state_nxt == RESP) && !fail;

  // Outputs decoded from state.
  always_comb begin
    req_ready_o = (state == IDLE) && !wb_rst_i;
    busy_o      = (state != IDLE);
    rsp_valid_o = (state == RESP);
  end

  // Bus beat registers and response registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      ct_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (handshake) begin
        ct_q  <= '0;
        err_q <= 1'b0;
      end
      if (issue) begin
        cyc_q <= 1'b1;
        we_q  <= beat_we;
        adr_q <= beat_adr;
        dat_q <= beat_dat;
      end else if (cyc_q && (wbm_ack_i || wbm_err_i)) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= '0;
        dat_q <= '0;
      end
      if (state == RD_CT && cyc_q && wbm_ack_i && !wbm_err_i)
        ct_q[(3 - idx[1:0]) * 32 +: 32] <= wbm_dat_i;
      if (fail) begin
        ct_q  <= '0;
        err_q <= 1'b1;
      end
    end
  end

  // Request operands carry no control meaning, so they are not reset.
  always_ff @(posedge wb_clk_i) begin
    if (handshake) begin
      key_q <= req_key_i;
      pt_q  <= req_pt_i;
    end
  end

`ifdef AES_SEQ_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_vld;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || fail) begin
      cache_vld <= 1'b0;
    end else if (resp_ok) begin
      cache_vld <= 1'b1;
      cache_key <= key_q;
    end
  end

  assign key_hit = cache_vld && (req_key_i == cache_key);
`else
  assign key_hit = 1'b0;
`endif

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign rsp_ct_o  = ct_q;
  assign rsp_err_o = err_q;

endmodule

// File: doc/aes_wb_sequencer.md
# aes_wb_sequencer

Wishbone master controller that runs one complete AES-128 encryption on the wishbone-based AES core per request. It accepts a 128-bit key and plaintext over a valid/ready request port. It then writes key and plaintext into the core, starts it, polls for completion, reads back the ciphertext and returns it on a valid/ready response port. It sits between an accelerator front end (DMA or test harness) and `aes_top_wb`, and replaces CPU-driven register sequencing over the AXI4-lite bridge.

## Interface
Parameters:
- `AW`, 30: wishbone word-address width.
- `PT_BASE`, 'h00: word address of plaintext word 0 (4 consecutive words).
- `KEY_BASE`, 'h04: word address of key word 0 (4 consecutive words).
- `START_ADDR`, 'h08: start register; writing 1 launches encryption.
- `DONE_ADDR`, 'h09: status register; bit 0 = done.
- `CT_BASE`, 'h0A: word address of ciphertext word 0 (4 consecutive words).
- `POLL_LIMIT`, 64: maximum DONE reads before timeout (≥1).

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_key_i` in 128, `req_pt_i` in 128: key and plaintext. Word 0 = bits [127:96].
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake.
- `rsp_ct_o` out 128: ciphertext (word 0 = bits [127:96]).
- `rsp_err_o` out 1: bus error or poll timeout.
- `busy_o` out 1: high whenever the FSM is not IDLE.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: wishbone master controls.
- `wbm_adr_o` out AW, `wbm_dat_o` out 32, `wbm_sel_o` out 4 (always 4'hF during a beat).
- `wbm_dat_i` in 32, `wbm_ack_i` in 1, `wbm_err_i` in 1.

## Operation
FSM states: IDLE → WR_KEY → WR_PT → WR_START → POLL → RD_CT → RESP → IDLE.
- IDLE: `req_ready_o`=1. A handshake (`req_valid_i` & `req_ready_o`) captures key and plaintext into internal registers and moves to WR_KEY.
- WR_KEY and WR_PT: 4 write beats each, words 0..3 to BASE+0..3.
- WR_START: 1 write beat of 32'h1 to START_ADDR.
- POLL: read beats to DONE_ADDR.
  - `wbm_dat_i[0]`=1 at ack → RD_CT.
  - Otherwise re-poll.
  - Done still 0 after the POLL_LIMIT-th read → RESP with error.
- RD_CT: 4 read beats. Word i is captured into `rsp_ct_o` slot i at its ack.
- RESP: `rsp_valid_o`=1 and held, with stable data, until `rsp_ready_i`; then IDLE.
- Error: `wbm_err_i` at any beat ends that beat and goes directly to RESP with `rsp_err_o`=1 and `rsp_ct_o`=0. The remaining beats are skipped.
- Poll counter: width $clog2(POLL_LIMIT+1). It clears on entry to POLL and does not wrap.
- `wbm_ack_i` and `wbm_err_i` asserted together: treated as err.
- `req_valid_i` outside IDLE is ignored; `req_ready_o`=0 there.

## Timing
- Beat: `wbm_cyc_o`, `wbm_stb_o`, `wbm_adr_o`, `wbm_dat_o` and `wbm_we_o` are registered. They rise the cycle after the beat is issued and hold until the cycle in which ack or err is sampled.
- The next edge after ack/err drives `wbm_cyc_o` = `wbm_stb_o` = 0 for exactly one idle cycle before the next beat.
- With a 1-cycle-ack slave, each beat takes 3 cycles. The first beat's `wbm_stb_o` rises 1 cycle after the request handshake.
- Best-case latency, handshake to `rsp_valid_o`, with done on the first poll: 14 beats × 3 = 42 cycles, plus 1.
- A wait state (ack delayed) stretches only that beat.
- Reset values:
  - `req_ready_o`=0 during reset, 1 on the first cycle after reset is released.
  - All other outputs 0; FSM in IDLE.
- Reset mid-operation: the next edge forces IDLE, `wbm_cyc_o`/`wbm_stb_o`=0 and `rsp_valid_o`=0. No response is issued for the aborted request.

## Configuration
- `AES_SEQ_KEY_CACHE_EN` defined: adds a 128-bit last-key register and a valid flag.
  - The flag is cleared by reset or by any error.
  - If the captured key equals the cached key and the flag is set, WR_KEY is skipped (IDLE → WR_PT).
  - On every entry to RESP without error, the flag is set and the cached key updated.
- Macro undefined: the 4 key writes are always issued, and no cache storage exists.

## Test plan
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, against a real `aes_top_wb` → `rsp_ct_o`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_err_o`=0. Bus trace shows beats in the order 4 key, 4 pt, start, poll(s), 4 ct, each separated by a cyc=0 cycle.
- Slave model that never sets done, POLL_LIMIT=4 → exactly 4 DONE reads, then `rsp_err_o`=1 and `rsp_ct_o`=0.
- `wbm_err_i` on the 2nd plaintext write → no further beats, response with `rsp_err_o`=1; next request completes normally.
- `rsp_ready_i` held low for 10 cycles → `rsp_valid_o` and `rsp_ct_o` stable, `req_ready_o`=0 throughout.
- `wb_rst_i` asserted during POLL → cyc/stb low on the next edge, no response; a subsequent FIPS vector passes.
- With `AES_SEQ_KEY_CACHE_EN`: two back-to-back requests with the same key → the second issues 0 key writes and gives the correct ciphertext; a third request with a different key issues 4 key writes.
